// File: rtl/slot_alloc16_pkg.sv
// Shared constants and types for the 16-slot allocator.
//   SLOTS     number of managed slots
//   IDX_W     width of a slot index
//   CNT_W     width of the allocated-slot counter (holds 0..SLOTS)
//   slot_idx_t  slot index type
//   popcount16  number of set bits in a 16-bit mask
package slot_alloc16_pkg;

  localparam int SLOTS = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 5;

  typedef logic [IDX_W-1:0] slot_idx_t;

  function automatic logic [CNT_W-1:0] popcount16(input logic [SLOTS-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < SLOTS; i++) begin
      n = n + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/slot_alloc16_pe16.sv
// pe16: 16-input priority encoder, lowest set bit wins.
//   in   request vector
//   bin  index of the lowest set bit (0 when in == 0)
//   vld  at least one bit of in is set
module pe16
  import slot_alloc16_pkg::*;
(
  input  logic [SLOTS-1:0] in,
  output slot_idx_t        bin,
  output logic             vld
);

  always_comb begin
    bin = '0;
    vld = |in;
    // Scan downward so the lowest set bit is the last to be written.
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (in[i]) bin = IDX_W'(i);
    end
  end

endmodule

// File: rtl/slot_alloc16.sv
// slot_alloc16: allocator for 16 slots, granting the lowest-numbered free slot.
//   clk, rst           clock, asynchronous active-high reset
//   alloc_req          request one slot this cycle
//   alloc_rdy          a free slot exists, alloc_idx is valid
//   alloc_idx          slot granted when alloc_req && alloc_rdy
//   free_vld, free_idx return one slot this cycle
//   free_err           pulse: last cycle's free hit an already-free slot
//   count              number of allocated slots (0..16)
//   full, empty        count == 16 / count == 0, registered
module slot_alloc16
  import slot_alloc16_pkg::*;
#(
  parameter logic [SLOTS-1:0] INIT_FREE = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_req,
  output logic             alloc_rdy,
  output slot_idx_t        alloc_idx,
  input  logic             free_vld,
  input  slot_idx_t        free_idx,
  output logic             free_err,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SLOTS) - popcount16(INIT_FREE);

  logic [SLOTS-1:0] mask;
  logic [SLOTS-1:0] mask_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             grant;
  logic             free_ok;
  logic             free_bad;

  pe16 u_pe16 (
    .in  (mask),
    .bin (alloc_idx),
    .vld (alloc_rdy)
  );

  assign grant    = alloc_req && alloc_rdy;
  assign free_ok  = free_vld && !mask[free_idx];
  assign free_bad = free_vld &&  mask[free_idx];

  // A valid free always targets an allocated slot and a grant always a free
  // one, so the two updates never touch the same bit.
  always_comb begin
    mask_nxt = mask;
    if (grant)   mask_nxt[alloc_idx] = 1'b0;
    if (free_ok) mask_nxt[free_idx]  = 1'b1;
    count_nxt = count + {{(CNT_W-1){1'b0}}, grant} - {{(CNT_W-1){1'b0}}, free_ok};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask     <= INIT_FREE;
      count    <= CNT_INIT;
      full     <= (CNT_INIT == CNT_W'(SLOTS));
      empty    <= (CNT_INIT == '0);
      free_err <= 1'b0;
    end else begin
      mask     <= mask_nxt;
      count    <= count_nxt;
      full     <= (count_nxt == CNT_W'(SLOTS));
      empty    <= (count_nxt == '0);
      free_err <= free_bad;
    end
  end

endmodule

// File: tb/tb_slot_alloc16.sv
// Directed testbench for slot_alloc16 with immediate-assertion checks.
module tb_slot_alloc16;
  import slot_alloc16_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             alloc_req;
  logic             alloc_rdy;
  slot_idx_t        alloc_idx;
  logic             free_vld;
  slot_idx_t        free_idx;
  logic             free_err;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  int checks = 0;
  int errors = 0;

  slot_alloc16 #(.INIT_FREE(16'hFFFF)) dut (
    .clk       (clk),
    .rst       (rst),
    .alloc_req (alloc_req),
    .alloc_rdy (alloc_rdy),
    .alloc_idx (alloc_idx),
    .free_vld  (free_vld),
    .free_idx  (free_idx),
    .free_err  (free_err),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int c, input logic rdy,
                           input int idx, input logic f, input logic e);
    chk({tag, ".count"}, 16'(count), 16'(c));
    chk({tag, ".rdy"},   16'(alloc_rdy), 16'(rdy));
    if (rdy) chk({tag, ".idx"}, 16'(alloc_idx), 16'(idx));
    chk({tag, ".full"},  16'(full), 16'(f));
    chk({tag, ".empty"}, 16'(empty), 16'(e));
  endtask

  initial begin
    rst = 1'b1; alloc_req = 1'b0; free_vld = 1'b0; free_idx = '0;
    step(); step();
    chk_state("reset", 0, 1'b1, 0, 1'b0, 1'b1);
    chk("reset.free_err", 16'(free_err), 16'd0);
    rst = 1'b0;
    step();

    // Free of an already-free slot after reset.
    free_vld = 1'b1; free_idx = 4'd5;
    step();
    free_vld = 1'b0;
    chk("ferr.pulse", 16'(free_err), 16'd1);
    chk_state("ferr", 0, 1'b1, 0, 1'b0, 1'b1);
    step();
    chk("ferr.drop", 16'(free_err), 16'd0);
    chk_state("ferr2", 0, 1'b1, 0, 1'b0, 1'b1);

    // Held request fills all 16 slots in order.
    alloc_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("fill.idx", 16'(alloc_idx), 16'(i));
      chk("fill.rdy", 16'(alloc_rdy), 16'd1);
      chk("fill.count", 16'(count), 16'(i));
      step();
    end
    chk_state("full", 16, 1'b0, 0, 1'b1, 1'b0);
    step();
    chk_state("full17", 16, 1'b0, 0, 1'b1, 1'b0);

    // Free slot 9 from full, then reallocate it.
    alloc_req = 1'b0; free_vld = 1'b1; free_idx = 4'd9;
    step();
    free_vld = 1'b0;
    chk_state("free9", 15, 1'b1, 9, 1'b0, 1'b0);
    alloc_req = 1'b1;
    step();
    alloc_req = 1'b0;
    chk_state("realloc9", 16, 1'b0, 0, 1'b1, 1'b0);

    // Simultaneous grant and valid free.
    rst = 1'b1; step(); rst = 1'b0;
    alloc_req = 1'b1;
    step(); step(); step(); step();
    chk_state("four", 4, 1'b1, 4, 1'b0, 1'b0);
    free_vld = 1'b1; free_idx = 4'd1;
    step();
    free_vld = 1'b0;
    chk_state("simul", 4, 1'b1, 1, 1'b0, 1'b0);
    chk("simul.ferr", 16'(free_err), 16'd0);
    step();
    chk_state("regrant1", 5, 1'b1, 5, 1'b0, 1'b0);

    // Free aimed at the slot being granted: grant proceeds, error pulses.
    free_vld = 1'b1; free_idx = 4'd5;
    step();
    free_vld = 1'b0;
    chk_state("selffree", 6, 1'b1, 6, 1'b0, 1'b0);
    chk("selffree.ferr", 16'(free_err), 16'd1);
    step();
    chk_state("count7", 7, 1'b1, 7, 1'b0, 1'b0);
    chk("count7.ferr", 16'(free_err), 16'd0);

    // Asynchronous reset mid-burst with a bad free in flight.
    free_vld = 1'b1; free_idx = 4'd12;
    #1 rst = 1'b1;
    #1;
    chk_state("arst", 0, 1'b1, 0, 1'b0, 1'b1);
    step();
    chk("arst.ferr", 16'(free_err), 16'd0);
    chk_state("arst2", 0, 1'b1, 0, 1'b0, 1'b1);
    alloc_req = 1'b0; free_vld = 1'b0;
    rst = 1'b0;
    step();

    // One alloc then free back to empty.
    alloc_req = 1'b1;
    step();
    alloc_req = 1'b0;
    chk_state("one", 1, 1'b1, 1, 1'b0, 1'b0);
    free_vld = 1'b1; free_idx = 4'd0;
    step();
    free_vld = 1'b0;
    chk_state("empty", 0, 1'b1, 0, 1'b0, 1'b1);
    chk("empty.ferr", 16'(free_err), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
